// File: rtl/vmask_feed.sv
// vmask_feed: turns one mask-reduction request into a stream of mask beats
// for the popcount stage.
//
// On start, the element count (vl), the unmasked flag (vm) and a
// destination tag are captured. The block then requests ceil(vl/DW) beats
// of vs2/v0 mask data and forwards each returned beat one cycle later as
// vs2 & (vm ? ones : v0) & tailmask. Elements past vl in the final beat
// are cleared. A vl of 0 produces a single all-zero end beat and issues
// no read requests.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   start             launch one operation (only honoured while idle)
//   in_vl/in_vm/in_addr  operation parameters, sampled with start
//   rd_req/rd_idx     beat request and its beat index
//   rd_ready          request accepted when rd_req && rd_ready
//   rd_valid          returned beat valid (in order, latency >= 1)
//   rd_vs2/rd_v0      returned vs2 and v0 mask beats
//   out_m0/out_valid/out_end/out_addr  beat stream toward the popcount stage
//   busy              operation in progress
module vmask_feed #(
    parameter int REQ_DATA_WIDTH = 64,
    parameter int REQ_ADDR_WIDTH = 32,
    parameter int VL_WIDTH       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [VL_WIDTH-1:0]       in_vl,
    input  logic                      in_vm,
    input  logic [REQ_ADDR_WIDTH-1:0] in_addr,
    output logic                      rd_req,
    output logic [VL_WIDTH-1:0]       rd_idx,
    input  logic                      rd_ready,
    input  logic                      rd_valid,
    input  logic [REQ_DATA_WIDTH-1:0] rd_vs2,
    input  logic [REQ_DATA_WIDTH-1:0] rd_v0,
    output logic [REQ_DATA_WIDTH-1:0] out_m0,
    output logic                      out_valid,
    output logic                      out_end,
    output logic [REQ_ADDR_WIDTH-1:0] out_addr,
    output logic                      busy
);

    localparam int DW = REQ_DATA_WIDTH;
    // Beat width expressed in the counter width; DW must be below 2^VL_WIDTH.
    localparam logic [VL_WIDTH-1:0] DW_V = VL_WIDTH'(REQ_DATA_WIDTH);
    localparam logic [VL_WIDTH-1:0] ONE  = VL_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        ZERO  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [VL_WIDTH-1:0]       nb_reg;         // beats in this operation
    logic [VL_WIDTH-1:0]       rem_reg;        // vl mod DW (valid bits of last beat)
    logic                      vm_reg;
    logic [REQ_ADDR_WIDTH-1:0] addr_reg;
    logic [VL_WIDTH-1:0]       issue_cnt_reg;  // requests accepted so far
    logic [VL_WIDTH-1:0]       rcv_cnt_reg;    // beats received so far

    logic [DW-1:0]             out_m0_reg;
    logic                      out_valid_reg;
    logic                      out_end_reg;
    logic [REQ_ADDR_WIDTH-1:0] out_addr_reg;

    // Beat count: quotient plus one for a partial final beat. Cannot
    // overflow because the result never exceeds vl itself.
    logic [VL_WIDTH-1:0] rem_calc;
    logic [VL_WIDTH-1:0] nb_calc;
    assign rem_calc = in_vl % DW_V;
    assign nb_calc  = (in_vl / DW_V) + ((rem_calc != '0) ? ONE : '0);

    logic req_fire;
    logic req_last;
    logic rx_fire;
    logic rx_last;
    assign req_fire = (state_reg == REQ) && rd_ready;
    assign req_last = (issue_cnt_reg == nb_reg - ONE);
    // Returns only count while an operation is receiving and not yet complete.
    assign rx_fire  = rd_valid && ((state_reg == REQ) || (state_reg == DRAIN))
                      && (rcv_cnt_reg != nb_reg);
    assign rx_last  = (rcv_cnt_reg == nb_reg - ONE);

    // Thermometer of valid element bits for a partial final beat;
    // a remainder of zero means the final beat is full.
    logic [DW-1:0] tail_mask;
    for (genvar gi = 0; gi < DW; gi++) begin : g_tail
        assign tail_mask[gi] = (rem_reg == '0) || (rem_reg > VL_WIDTH'(gi));
    end

    logic [DW-1:0] v0_term;
    logic [DW-1:0] tail_term;
    logic [DW-1:0] beat_m0;
    assign v0_term   = vm_reg  ? {DW{1'b1}} : rd_v0;
    assign tail_term = rx_last ? tail_mask  : {DW{1'b1}};
    assign beat_m0   = rd_vs2 & v0_term & tail_term;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (in_vl == '0) ? ZERO : REQ;
                end
            end
            REQ: begin
                if (req_fire && req_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (rx_fire && rx_last) begin
                    state_next = IDLE;
                end
            end
            ZERO: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nb_reg        <= '0;
            rem_reg       <= '0;
            vm_reg        <= 1'b0;
            addr_reg      <= '0;
            issue_cnt_reg <= '0;
            rcv_cnt_reg   <= '0;
            out_m0_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_end_reg   <= 1'b0;
            out_addr_reg  <= '0;
        end else begin
            if ((state_reg == IDLE) && start) begin
                nb_reg        <= nb_calc;
                rem_reg       <= rem_calc;
                vm_reg        <= in_vm;
                addr_reg      <= in_addr;
                issue_cnt_reg <= '0;
                rcv_cnt_reg   <= '0;
            end
            // Request and return counters advance independently.
            if (req_fire) begin
                issue_cnt_reg <= issue_cnt_reg + ONE;
            end
            if (rx_fire) begin
                rcv_cnt_reg <= rcv_cnt_reg + ONE;
            end

            out_m0_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_end_reg   <= 1'b0;
            out_addr_reg  <= '0;
            if (rx_fire) begin
                out_m0_reg    <= beat_m0;
                out_valid_reg <= 1'b1;
                out_end_reg   <= rx_last;
                out_addr_reg  <= addr_reg;
            end else if (state_reg == ZERO) begin
                // Empty vector: a single all-zero end beat.
                out_valid_reg <= 1'b1;
                out_end_reg   <= 1'b1;
                out_addr_reg  <= addr_reg;
            end
        end
    end

    assign rd_req    = (state_reg == REQ);
    assign rd_idx    = rd_req ? issue_cnt_reg : '0;
    assign busy      = (state_reg != IDLE);
    assign out_m0    = out_m0_reg;
    assign out_valid = out_valid_reg;
    assign out_end   = out_end_reg;
    assign out_addr  = out_addr_reg;

endmodule

// File: tb/tb_vmask_feed.sv
// Testbench for vmask_feed: randomized operations with an element-level
// reference model, a per-cycle compare of every output, and directed
// scenarios with hand-computed literal expectations.
module tb_vmask_feed;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int VW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [VW-1:0] in_vl = '0;
    logic          in_vm = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic          rd_req;
    logic [VW-1:0] rd_idx;
    logic          rd_ready = 1'b0;
    logic          rd_valid = 1'b0;
    logic [DW-1:0] rd_vs2 = '0;
    logic [DW-1:0] rd_v0 = '0;
    logic [DW-1:0] out_m0;
    logic          out_valid;
    logic          out_end;
    logic [AW-1:0] out_addr;
    logic          busy;

    always #5 clk = ~clk;

    vmask_feed #(
        .REQ_DATA_WIDTH(DW),
        .REQ_ADDR_WIDTH(AW),
        .VL_WIDTH(VW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_vl(in_vl), .in_vm(in_vm),
        .in_addr(in_addr), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_vs2(rd_vs2),
        .rd_v0(rd_v0), .out_m0(out_m0), .out_valid(out_valid),
        .out_end(out_end), .out_addr(out_addr), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state for the operation in flight
    bit            act = 1'b0;
    int            op_vl = 0;
    bit            op_vm = 1'b0;
    logic [AW-1:0] op_addr = '0;
    int            op_nb = 0;
    int            issued = 0;
    int            received = 0;
    logic [DW-1:0] vs2_mem [1024];
    logic [DW-1:0] v0_mem [1024];

    typedef struct {int due; int idx; bit stale;} ret_t;
    ret_t rq[$];
    int   last_due = 0;

    // Expected outputs for the current observation cycle
    bit            e_valid = 1'b0;
    bit            e_end = 1'b0;
    logic [DW-1:0] e_m0 = '0;
    logic [AW-1:0] e_addr = '0;

    // Stimulus controls
    bit            want_start = 1'b0;
    int            w_vl = 0;
    bit            w_vm = 1'b0;
    logic [AW-1:0] w_addr = '0;
    int            ready_pct = 100;
    int            lat_min = 1;
    int            lat_max = 1;
    int            stall_cnt = 0;
    bit            force_spur = 1'b0;

    // Observation logs for directed literal checks
    typedef struct {logic [DW-1:0] m0; bit e; logic [AW-1:0] a; bit b; int c;} ob_t;
    ob_t olog[$];
    int  rlog[$];
    int  start_cyc = 0;
    int  op_count = 0;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Element-level model: bit b of beat k is element k*DW+b; it is set
    // when the element lies below vl, vs2 is set and (unmasked or v0 set).
    function automatic logic [DW-1:0] ref_beat(int k);
        logic [DW-1:0] r;
        r = '0;
        for (int b = 0; b < DW; b++) begin
            int e;
            e = k * DW + b;
            if (e < op_vl && vs2_mem[k][b] && (op_vm || v0_mem[k][b])) r[b] = 1'b1;
        end
        return r;
    endfunction

    // One clock: compare at the falling edge, then drive the next inputs.
    task automatic step();
        bit            a0;
        bit            req_e;
        bit            n_valid;
        bit            n_end;
        logic [DW-1:0] n_m0;
        logic [AW-1:0] n_addr;
        @(negedge clk);
        cyc++;
        a0    = act;
        req_e = a0 && (op_vl > 0) && (issued < op_nb);

        chk("out_valid", out_valid, e_valid);
        chk("out_m0", out_m0, e_m0);
        chk("out_end", out_end, e_end);
        chk("out_addr", out_addr, e_addr);
        chk("busy", busy, a0);
        chk("rd_req", rd_req, req_e);
        if (req_e) chk("rd_idx", rd_idx, issued);
        if (out_valid) olog.push_back('{out_m0, out_end, out_addr, busy, cyc});

        n_valid = 1'b0;
        n_end   = 1'b0;
        n_m0    = '0;
        n_addr  = '0;

        // A start while busy must be ignored.
        start   = 1'b0;
        in_vl   = VW'($urandom);
        in_vm   = 1'($urandom);
        in_addr = $urandom;
        if (a0 && (force_spur || $urandom_range(0, 9) == 0)) begin
            start      = 1'b1;
            force_spur = 1'b0;
        end

        if (stall_cnt > 0) begin
            rd_ready = 1'b0;
            stall_cnt--;
        end else begin
            rd_ready = ($urandom_range(0, 99) < ready_pct);
        end
        if (req_e && rd_ready) begin
            int d;
            d = cyc + $urandom_range(lat_min, lat_max);
            if (d < last_due) d = last_due;
            last_due = d;
            rq.push_back('{d, issued, 1'b0});
            rlog.push_back(issued);
            issued++;
        end

        rd_valid = 1'b0;
        rd_vs2   = {$urandom, $urandom};
        rd_v0    = {$urandom, $urandom};
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            ret_t r;
            r = rq.pop_front();
            rd_valid = 1'b1;
            if (!r.stale) begin
                rd_vs2 = vs2_mem[r.idx];
                rd_v0  = v0_mem[r.idx];
                if (a0 && received < op_nb) begin
                    n_valid = 1'b1;
                    n_m0    = ref_beat(received);
                    n_end   = (received == op_nb - 1);
                    n_addr  = op_addr;
                    received++;
                    if (n_end) act = 1'b0;
                end
            end
        end else if (!a0 && rq.size() == 0 && $urandom_range(0, 3) == 0) begin
            rd_valid = 1'b1;  // stray return while idle: must be ignored
        end

        if (a0 && op_vl == 0) begin
            n_valid = 1'b1;
            n_end   = 1'b1;
            n_addr  = op_addr;
            act     = 1'b0;
        end

        if (want_start && !a0) begin
            want_start = 1'b0;
            start      = 1'b1;
            in_vl      = VW'(w_vl);
            in_vm      = w_vm;
            in_addr    = w_addr;
            op_vl      = w_vl;
            op_vm      = w_vm;
            op_addr    = w_addr;
            op_nb      = (w_vl + DW - 1) / DW;
            issued     = 0;
            received   = 0;
            act        = 1'b1;
            start_cyc  = cyc;
            op_count++;
            $display("op %0d: cycle %0d vl=%0d vm=%0d addr=%h beats=%0d",
                     op_count, cyc, w_vl, w_vm, w_addr, op_nb);
        end

        e_valid = n_valid;
        e_end   = n_end;
        e_m0    = n_m0;
        e_addr  = n_addr;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((act || want_start || rq.size() > 0) && n < 20000) begin
            step();
            n++;
        end
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got timeout expected idle (cycle %0d)", cyc);
        end
    endtask

    task automatic fill(int vl, bit rnd, logic [DW-1:0] vs2c, logic [DW-1:0] v0c);
        int nb;
        nb = (vl + DW - 1) / DW;
        for (int k = 0; k < nb; k++) begin
            vs2_mem[k] = rnd ? {$urandom, $urandom} : vs2c;
            v0_mem[k]  = rnd ? {$urandom, $urandom} : v0c;
        end
    endtask

    task automatic launch(int vl, bit vm, logic [AW-1:0] addr, bit rnd,
                          logic [DW-1:0] vs2c, logic [DW-1:0] v0c);
        wait_idle();
        fill(vl, rnd, vs2c, v0c);
        olog.delete();
        rlog.delete();
        w_vl = vl;
        w_vm = vm;
        w_addr = addr;
        want_start = 1'b1;
        wait_idle();
        step();
        step();
    endtask

    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    initial begin
        // Reset state
        repeat (3) step();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b1;
        repeat (2) step();

        // Single full beat, unmasked
        ready_pct = 100; lat_min = 1; lat_max = 1;
        launch(64, 1'b1, 32'hA5A5_0001, 1'b0, ONES, '0);
        chk("s1_nreq", rlog.size(), 1);
        if (rlog.size() == 1) chk("s1_idx", rlog[0], 0);
        chk("s1_nbeats", olog.size(), 1);
        if (olog.size() == 1) begin
            chk("s1_m0", olog[0].m0, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("s1_end", olog[0].e, 1'b1);
            chk("s1_addr", olog[0].a, 32'hA5A5_0001);
        end

        // vl=130: partial tail on beat 2
        launch(130, 1'b1, 32'h0000_0130, 1'b0, ONES, '0);
        chk("s2_nreq", rlog.size(), 3);
        chk("s2_nbeats", olog.size(), 3);
        if (olog.size() == 3) begin
            chk("s2_m0_0", olog[0].m0, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("s2_end_0", olog[0].e, 1'b0);
            chk("s2_m0_1", olog[1].m0, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("s2_m0_2", olog[2].m0, 64'h3);
            chk("s2_end_2", olog[2].e, 1'b1);
        end

        // Masked by v0
        launch(64, 1'b0, 32'h0000_0064, 1'b0, ONES, 64'h0F0F_0F0F_0F0F_0F0F);
        chk("s3_nbeats", olog.size(), 1);
        if (olog.size() == 1) chk("s3_m0", olog[0].m0, 64'h0F0F_0F0F_0F0F_0F0F);

        // vl=0: one zero end beat two cycles after start, busy already low
        launch(0, 1'b1, 32'hDEAD_0000, 1'b0, ONES, '0);
        chk("s4_nreq", rlog.size(), 0);
        chk("s4_nbeats", olog.size(), 1);
        if (olog.size() == 1) begin
            chk("s4_m0", olog[0].m0, 64'h0);
            chk("s4_end", olog[0].e, 1'b1);
            chk("s4_addr", olog[0].a, 32'hDEAD_0000);
            chk("s4_busy", olog[0].b, 1'b0);
            chk("s4_lat", olog[0].c - start_cyc, 2);
        end

        // Stalled requests, latency 4, a second start while busy
        lat_min = 4; lat_max = 4;
        wait_idle();
        fill(192, 1'b0, ONES, '0);
        olog.delete();
        rlog.delete();
        w_vl = 192; w_vm = 1'b1; w_addr = 32'h0000_0192;
        want_start = 1'b1;
        step();
        stall_cnt = 3;
        force_spur = 1'b1;
        wait_idle();
        step();
        step();
        chk("s5_nreq", rlog.size(), 3);
        if (rlog.size() == 3) chk("s5_idx2", rlog[2], 2);
        chk("s5_nbeats", olog.size(), 3);
        if (olog.size() == 3) begin
            chk("s5_end_1", olog[1].e, 1'b0);
            chk("s5_end_2", olog[2].e, 1'b1);
            chk("s5_addr_2", olog[2].a, 32'h0000_0192);
        end

        // Reset after the first of three beats
        lat_min = 1; lat_max = 3; ready_pct = 100;
        wait_idle();
        fill(192, 1'b0, ONES, '0);
        olog.delete();
        w_vl = 192; w_vm = 1'b1; w_addr = 32'h0000_0BAD;
        want_start = 1'b1;
        begin
            int n;
            n = 0;
            while (olog.size() < 1 && n < 100) begin
                step();
                n++;
            end
        end
        #1 rst = 1'b0;
        #1;
        chk("rst_rd_req", rd_req, 1'b0);
        chk("rst_rd_idx", rd_idx, '0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_m0", out_m0, '0);
        chk("rst_out_end", out_end, 1'b0);
        chk("rst_out_addr", out_addr, '0);
        chk("rst_busy", busy, 1'b0);
        act = 1'b0;
        e_valid = 1'b0; e_end = 1'b0; e_m0 = '0; e_addr = '0;
        for (int i = 0; i < rq.size(); i++) rq[i].stale = 1'b1;
        step();
        step();
        rst = 1'b1;
        wait_idle();
        repeat (3) step();
        begin
            int ends;
            ends = 0;
            foreach (olog[i]) if (olog[i].e) ends++;
            chk("s6_no_end", ends, 0);
        end
        launch(130, 1'b1, 32'h0000_C1EA, 1'b0, ONES, '0);
        chk("s6_clean_nbeats", olog.size(), 3);
        if (olog.size() == 3) chk("s6_clean_m0_2", olog[2].m0, 64'h3);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            int vl;
            case ($urandom_range(0, 5))
                0: vl = 0;
                1: vl = $urandom_range(1, 3) * DW;
                2: vl = $urandom_range(1, 3) * DW + 1;
                3: vl = $urandom_range(1, 3) * DW - 1;
                default: vl = $urandom_range(1, 500);
            endcase
            ready_pct = $urandom_range(30, 100);
            lat_min   = 1;
            lat_max   = $urandom_range(1, 6);
            launch(vl, 1'($urandom), $urandom, 1'b1, '0, '0);
        end

        // Largest vl
        ready_pct = 100; lat_min = 1; lat_max = 2;
        launch(65535, 1'b0, 32'h0000_FFFF, 1'b1, '0, '0);
        chk("big_nbeats", olog.size(), 1024);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vmask_feed.md
VMASK_FEED -- requirements
Module: vmask_feed

Interface
REQ-001 SHALL have parameter REQ_DATA_WIDTH, default 64, giving the mask beat width in bits (DW).
REQ-002 SHALL have parameter REQ_ADDR_WIDTH, default 32, giving the destination address tag width.
REQ-003 SHALL have parameter VL_WIDTH, default 16, giving the vector-length and beat-counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: launches one mask-reduction operand stream.
REQ-007 SHALL have port in_vl, input, VL_WIDTH bits: element count (vl), sampled at start.
REQ-008 SHALL have port in_vm, input, 1 bit: 1 means unmasked, 0 means AND each beat with v0; sampled at start.
REQ-009 SHALL have port in_addr, input, REQ_ADDR_WIDTH bits: destination tag, sampled at start.
REQ-010 SHALL have port rd_req, output, 1 bit: request for one mask beat.
REQ-011 SHALL have port rd_idx, output, VL_WIDTH bits: beat index of the current request.
REQ-012 SHALL have port rd_ready, input, 1 bit: a request is accepted when rd_req and rd_ready are both high.
REQ-013 SHALL have port rd_valid, input, 1 bit: returned beat valid; returns arrive in request order, with any latency of 1 or more cycles.
REQ-014 SHALL have ports rd_vs2 and rd_v0, input, DW bits each: the vs2 mask beat and the v0 mask beat.
REQ-015 SHALL have ports out_m0 (output, DW bits), out_valid (output, 1 bit), out_end (output, 1 bit) and out_addr (output, REQ_ADDR_WIDTH bits): the beat stream toward the popcount stage.
REQ-016 SHALL have port busy, output, 1 bit: an operation is in progress.

Function
REQ-017 SHALL implement the states IDLE, REQ, DRAIN and ZERO.
REQ-018 IDLE: start=1 SHALL latch vl/vm/addr, compute NB = ceil(vl/DW), and go to ZERO if vl=0, else to REQ; busy SHALL be 1 from the next cycle.
REQ-019 REQ: rd_req SHALL be 1 and rd_idx SHALL equal the issued count (starting at 0); each accepted request SHALL increment the count; the state SHALL go to DRAIN on the cycle the NB-th request is accepted.
REQ-020 DRAIN: rd_req SHALL be 0; when the NB-th beat is received, the state SHALL return to IDLE.
REQ-021 Each rd_valid received while the received count is below NB SHALL produce, one cycle later, out_valid=1 for one cycle, with out_m0 = rd_vs2 & (vm ? all-ones : rd_v0) & tailmask.
REQ-022 tailmask SHALL be all-ones except on beat NB-1 when vl mod DW != 0, where only bits [vl mod DW - 1 : 0] are set.
REQ-023 rd_valid SHALL be ignored when the received count equals NB, and in IDLE/ZERO.
REQ-024 Beats SHALL be accepted in both REQ and DRAIN; rd_valid in the same cycle as a request acceptance SHALL update both counters independently.
REQ-025 out_end SHALL be 1 only with out_valid on beat NB-1.
REQ-026 out_addr SHALL equal the latched in_addr on every out_valid cycle, and 0 otherwise.
REQ-027 out_m0 and out_end SHALL be 0 when out_valid=0.
REQ-028 ZERO: the block SHALL emit exactly one beat with out_valid=1, out_end=1, out_m0=0 and out_addr=latched addr, with no rd_req, then go to IDLE.
REQ-029 A start for vl=0 in cycle T SHALL produce that beat in cycle T+2.
REQ-030 busy SHALL drop in the cycle in which out_end is driven.
REQ-031 start SHALL be ignored while the state is not IDLE; the latched values SHALL be unchanged.
REQ-032 vl = 2^VL_WIDTH-1 SHALL be supported without counter overflow.

Reset
REQ-033 rst=0 SHALL immediately force state=IDLE and clear all counters and latched fields.
REQ-034 rst=0 SHALL force rd_req, rd_idx, out_m0, out_valid, out_end, out_addr and busy to 0.
REQ-035 A reset mid-operation SHALL abort the operation with no out_end; beats returned after reset release SHALL be ignored.

Verification (DW=64)
REQ-036 Scenario: vl=64, vm=1, rd_ready=1, 1-cycle return, vs2=all-ones -> one request idx 0; one beat out_m0=FFFF_FFFF_FFFF_FFFF, out_end=1, out_addr=tag.
REQ-037 Scenario: vl=130, vm=1, vs2=all-ones -> requests idx 0,1,2; beats 0 and 1 all-ones; beat 2 out_m0=0x3 with out_end=1.
REQ-038 Scenario: vl=64, vm=0, vs2=all-ones, v0=0x0F0F_0F0F_0F0F_0F0F -> out_m0=0x0F0F_0F0F_0F0F_0F0F.
REQ-039 Scenario: vl=0, start at cycle T -> no rd_req; out_valid=out_end=1 with out_m0=0 at T+2; busy=0 in that cycle.
REQ-040 Scenario: vl=192, rd_ready low 3 cycles, return latency 4, second start issued while busy -> idx held while stalled; exactly 3 beats in order; second start ignored.
REQ-041 Scenario: rst=0 after 1 of 3 beats -> all outputs 0 at once; no out_end; the next start runs a clean operation.
